// File: rtl/fp_wb_arb_pkg.sv
// Shared types and helpers for the FP div/sqrt writeback result arbiter.
// Arbitration mode is chosen in rr_arbiter by FP_WB_ARB_RR_EN.
package fp_wb_arb_pkg;

    localparam int FP_WB_MAX_SRC    = 8;
    localparam int FP_WB_IDX_W      = 3;
    localparam int FP_WB_MAX_ID_W   = 8;
    localparam int FP_WB_MAX_DATA_W = 64;

    typedef struct packed {
        logic [FP_WB_MAX_ID_W-1:0]   id;
        logic [FP_WB_MAX_DATA_W-1:0] rd;
    } fp_wb_src_t;

    // OR-reduction of the set bit's position; only meaningful for one-hot or zero input.
    function automatic logic [FP_WB_IDX_W-1:0] onehot_to_idx(input logic [FP_WB_MAX_SRC-1:0] oh);
        logic [FP_WB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < FP_WB_MAX_SRC; i++) begin
            if (oh[i]) idx = idx | FP_WB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter: round-robin with FP_WB_ARB_RR_EN defined,
// otherwise fixed priority (lowest index wins, no history register).
module rr_arbiter
    import fp_wb_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant
);

`ifdef FP_WB_ARB_RR_EN
    localparam int IDX_W = $clog2(NUM_SRC);

    logic [IDX_W-1:0] last_grant;
    logic             hit_hi;
    logic             hit_lo;

    // First pass searches above last_grant, second pass wraps to the bottom.
    always_comb begin
        grant  = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!hit_hi && req[i] && (i > int'(last_grant))) begin
                grant[i] = 1'b1;
                hit_hi   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!hit_hi && !hit_lo && req[i]) begin
                grant[i] = 1'b1;
                hit_lo   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_SRC - 1);
        end else if (advance && (|grant)) begin
            last_grant <= IDX_W'(onehot_to_idx(FP_WB_MAX_SRC'(grant)));
        end
    end
`else
    logic hit;
    logic unused_rr;

    assign unused_rr = &{1'b0, clk, rst, advance};

    always_comb begin
        grant = '0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!hit && req[i]) begin
                grant[i] = 1'b1;
                hit      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/fp_wb_rr_arbiter.sv
// Writeback result arbiter for the FP div/sqrt unit: registered output slot fed
// from NUM_SRC result streams; fairness mode set by FP_WB_ARB_RR_EN in rr_arbiter.
module fp_wb_rr_arbiter
    import fp_wb_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 34,
    parameter int ID_W    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*ID_W-1:0]  src_id,
    input  logic [NUM_SRC*DATA_W-1:0] src_rd,
    output logic [NUM_SRC-1:0]       src_taken,
    output logic                     wb_done,
    output logic [ID_W-1:0]          wb_id,
    output logic [DATA_W-1:0]        wb_rd,
    input  logic                     wb_ack
);

    logic                   load;
    logic [NUM_SRC-1:0]     grant;
    logic [FP_WB_IDX_W-1:0] sel;
    logic [ID_W-1:0]        sel_id;
    logic [DATA_W-1:0]      sel_rd;

    assign load      = (!wb_done || wb_ack) && !rst;
    assign src_taken = load ? grant : '0;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid),
        .advance (load),
        .grant   (grant)
    );

    assign sel = onehot_to_idx(FP_WB_MAX_SRC'(grant));

    always_comb begin
        sel_id = '0;
        sel_rd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == FP_WB_IDX_W'(i)) begin
                sel_id = src_id[i*ID_W +: ID_W];
                sel_rd = src_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    // An unacked result is dropped on reset; the upstream flush re-issues it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_done <= 1'b0;
            wb_id   <= '0;
            wb_rd   <= '0;
        end else if (load) begin
            if (|src_valid) begin
                wb_done <= 1'b1;
                wb_id   <= sel_id;
                wb_rd   <= sel_rd;
            end else begin
                wb_done <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fp_wb_rr_arbiter.md
# fp_wb_rr_arbiter

Result arbiter for the shared FP divide/square-root datapath. It merges NUM_SRC independently pipelined result streams (stream 0 = divide, stream 1 = square root, further streams optional) onto the single unit writeback port. It uses a registered output slot, round-robin fairness and full one-result-per-cycle throughput. It replaces the fixed-priority output select at the tail of the div/sqrt unit, so a continuously busy divide pipe can no longer starve square root.

## Interface
Parameters:
- NUM_SRC, 2, number of result streams (2..8)
- DATA_W, 34, result width (FloPoCo single-precision format)
- ID_W, 3, instruction id width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- src_valid  in  NUM_SRC  stream i has a result; must hold, with stable id/rd, until taken
- src_id  in  NUM_SRC×ID_W  per-stream id
- src_rd  in  NUM_SRC×DATA_W  per-stream result
- src_taken  out  NUM_SRC  one-hot; result of stream i consumed this cycle (drives that stream's advance)
- wb_done  out  1  output slot holds a valid result
- wb_id  out  ID_W  id of held result
- wb_rd  out  DATA_W  held result
- wb_ack  in  1  writeback consumes held result this cycle

## Operation
- Output slot state: wb_done / wb_id / wb_rd registers.
- load = (!wb_done || wb_ack) && !rst.
- grant = arbitration over src_valid (one-hot or zero).
- src_taken = grant when load, else 0.
- On a clock edge with load:
  - If any src_valid: the slot captures the granted stream's id/rd and wb_done is set to 1.
  - If no src_valid: wb_done is set to 0.
- On a clock edge without load: the slot holds; wb_id and wb_rd stay stable while wb_done=1 and wb_ack=0.
- wb_ack while wb_done=0 is ignored.
- Round-robin:
  - last_grant register, log2(NUM_SRC) bits.
  - Search starts at last_grant+1 and wraps modulo NUM_SRC.
  - last_grant updates only on an edge where load and a grant occur.
- Fairness bound: a stream holding valid is taken within NUM_SRC grants.
- Reset (async, any time including mid-transfer):
  - wb_done=0, wb_id=0, wb_rd=0, last_grant=NUM_SRC-1, so stream 0 has first priority.
  - src_taken=0 while rst is high.
  - A held, un-acked result is discarded; the pipeline flush upstream covers it.

## Timing
- Latency: src_valid[i] in cycle t with slot free or acked → src_taken[i]=1 in cycle t; wb_done=1 with that result in cycle t+1.
- Throughput: with wb_ack tied high, one result per cycle and no bubbles.
- Ack and load in the same cycle replace the slot contents on that edge.
- src_taken is combinational from wb_ack, wb_done and src_valid. There is no path from src_taken back to src_valid.
- Backpressure: wb_ack=0 with wb_done=1 gives src_taken=0 and a frozen slot.

## Configuration
- FP_WB_ARB_RR_EN defined: round-robin as above.
- FP_WB_ARB_RR_EN undefined:
  - Fixed priority: the lowest-index valid stream wins.
  - The last_grant register is removed.
  - Starvation of higher indices is permitted.
  - All other timing is identical.

## Structure
- Shared package fp_wb_arb_pkg holds:
  - FP_WB_MAX_SRC = 8
  - typedef fp_wb_src_t (id, rd)
  - function onehot_to_idx
- One sub-module, rr_arbiter (NUM_SRC):
  - Inputs: clk, rst, req, advance. Output: one-hot grant.
  - Owns last_grant and the FP_WB_ARB_RR_EN selection.
- The top level holds only the output slot and the load/taken logic.

## Test plan
- Reset: rst=1 with src_valid=2'b11 → src_taken=0, wb_done=0, wb_id=0, wb_rd=0. Release rst, wb_ack=1 → first grant to stream 0.
- Single stream: cycle 0 src_valid=2'b10, src_id[1]=5, src_rd[1]=0x0_3F800000, wb_ack=1 → src_taken=2'b10 in cycle 0; cycle 1 wb_done=1, wb_id=5, wb_rd=0x0_3F800000.
- Contention, RR: both streams valid continuously, ids 1 (div) and 2 (sqrt), wb_ack=1 → wb_id sequence 1,2,1,2 on cycles 1–4, src_taken alternating 01/10.
- Backpressure: slot full, wb_ack=0 for 3 cycles, both valid → src_taken=0 and wb_id/wb_rd constant. Cycle 4 wb_ack=1 → the other stream is granted and the slot updates in cycle 5.
- Drain: single result, wb_ack=1, no further valid → wb_done 1 for exactly one cycle, then 0. wb_ack pulsed while wb_done=0 → no state change.
- Macro off: both valid continuously, wb_ack=1 → src_taken=01 every cycle and wb_id constant at stream 0's id.
